// File: rtl/sdram_master_arbiter.sv
// Two-master Avalon-MM arbiter in front of one SDRAM controller slave: m0 (video) has priority, m1 is starvation-protected.
// Zero-latency combinational command mux; a tag FIFO routes in-order read data back to the issuing master.
module sdram_master_arbiter #(
  parameter int ADDR_W     = 25,
  parameter int DATA_W     = 16,
  parameter int MAX_OUTSTD = 8,
  parameter int M0_HOLD    = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   m0_address,
  input  logic                m0_read,
  output logic                m0_waitrequest,
  output logic [DATA_W-1:0]   m0_readdata,
  output logic                m0_readdatavalid,
  input  logic [ADDR_W-1:0]   m1_address,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [DATA_W-1:0]   m1_writedata,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  output logic                m1_waitrequest,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic                m1_readdatavalid,
  output logic [ADDR_W-1:0]   s_address,
  output logic                s_read,
  output logic                s_write,
  output logic [DATA_W-1:0]   s_writedata,
  output logic [DATA_W/8-1:0] s_byteenable,
  input  logic                s_waitrequest,
  input  logic [DATA_W-1:0]   s_readdata,
  input  logic                s_readdatavalid,
  output logic                err_orphan
);
  localparam int CNT_W = $clog2(MAX_OUTSTD + 1);
  localparam int PTR_W = (MAX_OUTSTD > 1) ? $clog2(MAX_OUTSTD) : 1;
  localparam int STV_W = $clog2(M0_HOLD + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(MAX_OUTSTD);
  localparam logic [STV_W-1:0] STV_MAX  = STV_W'(M0_HOLD);

  typedef enum logic {ST_OPEN = 1'b0, ST_LOCKED = 1'b1} lock_e;

  lock_e            lock_q, lock_d;
  logic             owner_q, owner_d;
  logic [STV_W-1:0] starve_q, starve_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic             orphan_q, orphan_d;
  logic             tag_q [MAX_OUTSTD];
  logic             req1, full, m0_elig, m1_elig, sel, cmd_vld, accept, push, pop;

  always_comb begin
    req1    = m1_read | m1_write;
    full    = (count_q == CNT_FULL);
    m0_elig = m0_read & ~full;
    m1_elig = m1_write | (m1_read & ~full);
    // A stalled command keeps the mux frozen until the slave takes it.
    if (lock_q == ST_LOCKED)                                  sel = owner_q;
    else if (m1_elig && (!m0_elig || starve_q == STV_MAX))    sel = 1'b1;
    else if (m0_elig)                                         sel = 1'b0;
    else                                                      sel = owner_q;

    s_read       = ~reset & ~full & (sel ? m1_read : m0_read);
    s_write      = ~reset & sel & m1_write;
    s_address    = sel ? m1_address : m0_address;
    s_writedata  = m1_writedata;
    s_byteenable = sel ? m1_byteenable : '1;
    cmd_vld      = s_read | s_write;
    accept       = cmd_vld & ~s_waitrequest;
    m0_waitrequest = ~(accept & ~sel);
    m1_waitrequest = ~(accept & sel);

    push = accept & s_read;
    pop  = ~reset & s_readdatavalid & (count_q != '0);
    m0_readdatavalid = pop & ~tag_q[rd_ptr_q];
    m1_readdatavalid = pop & tag_q[rd_ptr_q];
    m0_readdata = s_readdata;
    m1_readdata = s_readdata;
    err_orphan  = orphan_q;

    lock_d = lock_q;
    if (cmd_vld) lock_d = s_waitrequest ? ST_LOCKED : ST_OPEN;
    owner_d = sel;

    starve_d = starve_q;
    if (accept && sel)                                  starve_d = '0;
    else if (accept && req1 && starve_q != STV_MAX)     starve_d = starve_q + 1'b1;

    count_d = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (!push && pop) count_d = count_q - 1'b1;
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    orphan_d = orphan_q | (~reset & s_readdatavalid & (count_q == '0));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lock_q   <= ST_OPEN;
      owner_q  <= 1'b0;
      starve_q <= '0;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      orphan_q <= 1'b0;
    end else begin
      lock_q   <= lock_d;
      owner_q  <= owner_d;
      starve_q <= starve_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      orphan_q <= orphan_d;
      if (push) tag_q[wr_ptr_q] <= sel;
    end
  end
endmodule

// File: tb/tb_sdram_master_arbiter.sv
// Directed bench for sdram_master_arbiter with an in-order slave model and per-master read-data scoreboards.
module tb_sdram_master_arbiter;
  localparam int AW = 25, DW = 16, LAT = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic [AW-1:0] m0_address, m1_address, s_address;
  logic          m0_read, m0_waitrequest, m0_readdatavalid;
  logic [DW-1:0] m0_readdata, m1_readdata, m1_writedata, s_writedata, s_readdata;
  logic          m1_read, m1_write, m1_waitrequest, m1_readdatavalid;
  logic [1:0]    m1_byteenable, s_byteenable;
  logic          s_read, s_write, s_waitrequest, s_readdatavalid, err_orphan;

  sdram_master_arbiter dut (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_read(m0_read), .m0_waitrequest(m0_waitrequest),
    .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
    .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
    .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .s_address(s_address), .s_read(s_read), .s_write(s_write), .s_writedata(s_writedata),
    .s_byteenable(s_byteenable), .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
    .s_readdatavalid(s_readdatavalid), .err_orphan(err_orphan)
  );

  int total = 0, passed = 0, cyc = 0;
  int acc_cnt, rdv0_cnt, rdv1_cnt;
  bit slave_en = 1'b1, m0_acc, m1_acc;
  logic [DW-1:0] exp0_q[$], exp1_q[$], pend_dat[$];
  int pend_due[$], grant_log[$], rdv_log[$];

  function automatic logic [DW-1:0] dfn(input logic [AW-1:0] a);
    return a[DW-1:0] ^ 16'h5A3C;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  // Samples one settled cycle: records accepts into the slave model and scoreboards, checks returned data.
  task automatic observe();
    m0_acc = 1'b0;
    m1_acc = 1'b0;
    if ((s_read || s_write) && !s_waitrequest) begin
      acc_cnt++;
      if (!m0_waitrequest) begin m0_acc = 1'b1; grant_log.push_back(0); exp0_q.push_back(dfn(m0_address)); end
      if (!m1_waitrequest) begin
        m1_acc = 1'b1;
        grant_log.push_back(1);
        if (m1_read) exp1_q.push_back(dfn(m1_address));
      end
      if (s_read && slave_en) begin pend_due.push_back(cyc + LAT); pend_dat.push_back(dfn(s_address)); end
    end
    if (m0_readdatavalid) begin
      rdv0_cnt++; rdv_log.push_back(0);
      if (exp0_q.size() == 0) chk("m0_rdv_unexpected", 1, 0);
      else chk("m0_rdata", m0_readdata, exp0_q.pop_front());
    end
    if (m1_readdatavalid) begin
      rdv1_cnt++; rdv_log.push_back(1);
      if (exp1_q.size() == 0) chk("m1_rdv_unexpected", 1, 0);
      else chk("m1_rdata", m1_readdata, exp1_q.pop_front());
    end
  endtask

  task automatic clk_step();
    #1;
    observe();
    @(posedge clk);
    cyc++;
    #1;
    if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
      s_readdatavalid = 1'b1;
      s_readdata = pend_dat.pop_front();
      pend_due.delete(0);
    end else begin
      s_readdatavalid = 1'b0;
      s_readdata = '0;
    end
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 40 && (exp0_q.size() + exp1_q.size() + pend_due.size()) > 0; i++) clk_step();
    chk(tag, exp0_q.size() + exp1_q.size() + pend_due.size(), 0);
  endtask

  task automatic clear_stats();
    acc_cnt = 0; rdv0_cnt = 0; rdv1_cnt = 0;
    grant_log.delete(); rdv_log.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; m0_address = '0; m0_read = 0; m1_address = '0; m1_read = 0; m1_write = 0;
    m1_writedata = '0; m1_byteenable = '0; s_waitrequest = 0; s_readdata = '0; s_readdatavalid = 0;
    clear_stats();

    // Reset state, with a request held during reset.
    clk_step();
    m0_read = 1'b1; #1;
    chk("rst_hold", {s_read, s_write, m0_waitrequest, m1_waitrequest, err_orphan}, 5'b00110);
    clk_step();
    reset = 1'b0; m0_read = 1'b0; #1;
    chk("rst_state", {s_read, s_write, m0_waitrequest, m1_waitrequest,
                      m0_readdatavalid, m1_readdatavalid, err_orphan}, 7'b0011000);

    // 1: m0 alone reads 0x100..0x103.
    clear_stats();
    m0_address = 25'h100; m0_read = 1'b1; #1;
    chk("t1_zero_lat", {s_read, s_address, s_byteenable, m0_waitrequest}, {1'b1, 25'h100, 2'b11, 1'b0});
    for (int i = 0; i < 40 && acc_cnt < 4; i++) begin clk_step(); if (m0_acc) m0_address++; end
    m0_read = 1'b0;
    drain("t1_drain");
    chk("t1_accepts", acc_cnt, 4);
    chk("t1_m0_rdv", rdv0_cnt, 4);
    chk("t1_m1_quiet", rdv1_cnt, 0);

    // 2: both masters read continuously; m1 gets one slot after every 16 m0 accepts.
    clear_stats();
    m0_address = 25'h200; m1_address = 25'h300; m0_read = 1'b1; m1_read = 1'b1;
    for (int i = 0; i < 300 && grant_log.size() < 34; i++) begin
      clk_step();
      if (m0_acc) m0_address++;
      if (m1_acc) m1_address++;
    end
    m0_read = 1'b0; m1_read = 1'b0;
    chk("t2_grants", grant_log.size(), 34);
    for (int k = 0; k < 34 && k < grant_log.size(); k++)
      chk($sformatf("t2_owner_%0d", k), grant_log[k], (k % 17 == 16) ? 1 : 0);
    drain("t2_drain");

    // 3: stalled m1 write must hold the mux even when m0 starts requesting.
    clear_stats();
    m1_write = 1'b1; m1_address = 25'h20; m1_writedata = 16'hBEEF; m1_byteenable = 2'b11; s_waitrequest = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin m0_read = 1'b1; m0_address = 25'h400; end
      #1;
      chk($sformatf("t3_hold_%0d", i), {s_write, s_read, s_address, s_writedata, s_byteenable},
          {1'b1, 1'b0, 25'h20, 16'hBEEF, 2'b11});
      chk($sformatf("t3_wait_%0d", i), {m0_waitrequest, m1_waitrequest}, 2'b11);
      clk_step();
    end
    s_waitrequest = 1'b0; #1;
    chk("t3_accept", {s_write, m1_waitrequest, m0_waitrequest}, 3'b101);
    clk_step();
    chk("t3_m1_acc", m1_acc, 1);
    m1_write = 1'b0; #1;
    chk("t3_m0_next", {s_read, s_address, m0_waitrequest}, {1'b1, 25'h400, 1'b0});
    clk_step();
    m0_read = 1'b0;
    drain("t3_drain");

    // 5: interleaved reads are routed back to their issuers; then an orphan response.
    clear_stats();
    for (int j = 0; j < 4; j++) begin
      if (j % 2 == 0) begin m0_address = 25'h500 + j; m0_read = 1'b1; end
      else begin m1_address = 25'h600 + j; m1_read = 1'b1; end
      for (int i = 0; i < 10; i++) begin clk_step(); if (m0_acc || m1_acc) break; end
      m0_read = 1'b0; m1_read = 1'b0;
    end
    drain("t5_drain");
    chk("t5_rdv_count", rdv_log.size(), 4);
    for (int j = 0; j < 4 && j < rdv_log.size(); j++)
      chk($sformatf("t5_route_%0d", j), rdv_log[j], j % 2);
    chk("t5_orphan_pre", err_orphan, 0);
    s_readdatavalid = 1'b1; s_readdata = 16'hDEAD; #1;
    chk("t5_orphan_no_rdv", {m0_readdatavalid, m1_readdatavalid}, 2'b00);
    clk_step(); #1;
    chk("t5_orphan_set", err_orphan, 1);
    for (int i = 0; i < 3; i++) clk_step();
    #1;
    chk("t5_orphan_sticky", err_orphan, 1);

    // 4: slave silent; throttle at 8 outstanding, write still passes, 9th read after first pop.
    clear_stats();
    slave_en = 1'b0;
    m0_address = 25'h700; m0_read = 1'b1;
    for (int i = 0; i < 12; i++) begin clk_step(); if (m0_acc) m0_address++; end
    chk("t4_accepts", acc_cnt, 8);
    #1;
    chk("t4_full_block", {s_read, m0_waitrequest}, 2'b01);
    m1_write = 1'b1; m1_address = 25'h40; m1_writedata = 16'h1234; m1_byteenable = 2'b01; #1;
    chk("t4_write_full", {s_write, s_byteenable, m1_waitrequest}, 4'b1010);
    clk_step();
    chk("t4_write_acc", m1_acc, 1);
    m1_write = 1'b0;
    s_readdatavalid = 1'b1; s_readdata = dfn(25'h700); #1;
    chk("t4_pop_cycle_block", {s_read, m0_waitrequest, m0_readdatavalid}, 3'b011);
    clk_step(); #1;
    chk("t4_ninth", {s_read, m0_waitrequest, s_address}, {1'b1, 1'b0, 25'h708});
    clk_step();
    chk("t4_ninth_acc", m0_acc, 1);
    m0_read = 1'b0;
    for (int k = 0; k < 5; k++) begin
      s_readdatavalid = 1'b1; s_readdata = dfn(25'h701 + k);
      clk_step();
    end
    chk("t4_popped", rdv0_cnt, 6);

    // 6: reset with 3 reads outstanding clears FIFO, lock and the sticky error.
    reset = 1'b1; m0_read = 1'b1; m0_address = 25'h900; #1;
    chk("t6_in_reset", {s_read, s_write, m0_waitrequest, m1_waitrequest}, 4'b0011);
    clk_step();
    reset = 1'b0; m0_read = 1'b0;
    exp0_q.delete(); exp1_q.delete();
    #1;
    chk("t6_after", {s_read, m0_waitrequest, m1_waitrequest, err_orphan}, 4'b0110);
    s_readdatavalid = 1'b1; s_readdata = 16'h0BAD; #1;
    chk("t6_fifo_empty", {m0_readdatavalid, m1_readdatavalid}, 2'b00);
    clk_step(); #1;
    chk("t6_orphan", err_orphan, 1);
    slave_en = 1'b1; clear_stats();
    m0_address = 25'hA00; m0_read = 1'b1;
    for (int i = 0; i < 10 && acc_cnt < 1; i++) clk_step();
    m0_read = 1'b0;
    drain("t6_drain");
    chk("t6_resume", rdv0_cnt, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
